m_piso_transmitter: RTL
=======================

# m_piso_transmitter

Parallel-in serial-out transmitter: the sending end of the serial link whose receiving end is `m_siporegister`. It accepts a WIDTH-bit word through a valid/ready load handshake, then drives it out one bit per clock on `SO` with a frame qualifier and last-bit marker. With the default MSB-first order, a `m_siporegister` sampling `SO` on the same edges holds the original word on its `PO` after WIDTH shift clocks.

## Interface
- `WIDTH`, default 4: word length in bits; legal range is 2 to 32.
- `MSB_FIRST`, default 1: 1 sends `PI[WIDTH-1]` first; 0 sends `PI[0]` first.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `CLR`  in  1: reset; synchronous, active-high.
- `LOAD_VALID`  in  1: `PI` holds a word to send.
- `LOAD_READY`  out  1: the block can accept a word this cycle.
- `PI`  in  WIDTH: parallel word; sampled only on an accepted load.
- `SO`  out  1: serial data.
- `SO_VALID`  out  1: `SO` carries a frame bit this cycle.
- `SO_LAST`  out  1: `SO` carries the final bit of the current word.

## Operation
- FSM states are IDLE and SHIFT.
  - IDLE: `LOAD_READY`=1, `SO_VALID`=0, `SO`=0.
  - SHIFT: `SO_VALID`=1, and `SO` equals the current output bit of the shift register.
- A load is accepted on a rising edge with `LOAD_VALID`=1 and `LOAD_READY`=1.
  - `PI` is copied into the shift register and the bit counter is set to WIDTH-1.
  - The FSM moves to SHIFT.
- While in SHIFT, each edge shifts one position (left when MSB_FIRST=1, right otherwise) and decrements the counter.
- `SO_LAST`=1 when in SHIFT and counter = 0.
- `LOAD_READY` = IDLE, or (SHIFT and counter = 0). This allows back-to-back frames with no gap.
- On the last bit:
  - If a load is accepted, the new word is loaded and the FSM stays in SHIFT.
  - Otherwise the FSM returns to IDLE.
- `LOAD_VALID` is ignored while `LOAD_READY`=0. Changes on `PI` after acceptance have no effect on the word in flight.
- Shifted-in fill bits are 0. They are never visible on `SO` while `SO_VALID`=1.
- `CLR`=1 at an edge, including mid-frame:
  - FSM goes to IDLE, shift register and counter clear to 0.
  - `SO`, `SO_VALID` and `SO_LAST` are 0 from the next cycle.
  - Any load offered in the same cycle is dropped, because `CLR` has priority.

## Timing
- Reset values: `SO`=0, `SO_VALID`=0, `SO_LAST`=0, `LOAD_READY`=1.
- Latency: a load accepted at edge N puts bit 0 of the frame on `SO` in the cycle following edge N.
  - Bit k appears after edge N+k; the last bit appears after edge N+WIDTH-1.
- Frame length: exactly WIDTH cycles of `SO_VALID`=1. `SO_LAST` is high for exactly one of those cycles, the final one.
- `LOAD_READY` is combinational from state only; it never depends on `LOAD_VALID`.
- Continuous streaming (load accepted on every last bit) gives 100 % link utilization with no idle cycle between frames.
- All outputs are registered, except `LOAD_READY` and `SO_LAST`, which are decoded from registered state.

## Structure
- Shared include `shift_defs.vh` holds the state encodings (`ST_IDLE`=1'b0, `ST_SHIFT`=1'b1) and the default WIDTH. `m_siporegister` and this block take WIDTH from the same definition.
- One natural sub-module, `m_bit_counter`: a loadable down-counter of width clog2(WIDTH) with a `zero` flag. The FSM and shift register stay in the top-level module.

## Test plan
- Load 4'b1101 after reset (MSB_FIRST=1) -> `SO` = 1,1,0,1 on four consecutive cycles, `SO_VALID`=1 for all four, `SO_LAST`=1 only on the 4th, then IDLE with `LOAD_READY`=1.
- Loopback: drive `SO` into `m_siporegister` `SI` on the same `CLK`, load 4'b1101 -> `PO`=4'b1101 on the edge after the last bit.
- Back-to-back: hold `LOAD_VALID`=1 and present 4'b1101, then 4'b0110 on the first word's last-bit cycle -> eight contiguous `SO_VALID` cycles carrying 1,1,0,1,0,1,1,0, with `SO_LAST` on cycles 4 and 8.
- MSB_FIRST=0, load 4'b1101 -> `SO` = 1,0,1,1.
- Load 4'b1010, then assert `CLR` on the 2nd bit cycle while `LOAD_VALID`=1 -> all outputs 0 and `LOAD_READY`=1 the next cycle, no frame in progress, offered word not sent.
- During a frame, pulse `LOAD_VALID` with `PI`=4'b0000 on a non-last cycle -> ignored; the current frame completes unchanged and no second frame starts.

Source files
------------

// File: rtl/m_piso_transmitter_pkg.sv
// Shared definitions for the PISO transmitter: FSM state encoding, default
// word width and the bit-counter width helper.
package m_piso_transmitter_pkg;

  // FSM states; encodings match the receiver side of the link.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Default word length shared with m_siporegister.
  localparam int unsigned DEFAULT_WIDTH = 4;

  // Counter width able to hold WIDTH-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/m_bit_counter.sv
// Loadable down-counter with a zero flag. Tracks the remaining bits of the
// frame in flight.
// Ports:
//   clk        - clock, rising edge
//   clr        - synchronous active-high clear (highest priority)
//   load       - load load_value
//   dec        - decrement by one
//   load_value - value taken on load
//   count      - current count (registered)
//   zero       - count == 0
module m_bit_counter #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] count,
  output logic          zero
);

  // Count register: clear, then load, then decrement.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/m_piso_transmitter.sv
// Parallel-in serial-out transmitter. Accepts a WIDTH-bit word through a
// valid/ready handshake and sends it one bit per clock with a frame
// qualifier and a last-bit marker; back-to-back frames need no gap.
// Ports:
//   CLK        - clock, rising edge
//   CLR        - synchronous active-high reset
//   LOAD_VALID - PI holds a word to send
//   LOAD_READY - word can be accepted this cycle (decoded from state)
//   PI         - parallel word, sampled on an accepted load
//   SO         - serial data (registered)
//   SO_VALID   - SO carries a frame bit (registered)
//   SO_LAST    - SO carries the final bit of the word (decoded from state)
module m_piso_transmitter
  import m_piso_transmitter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] PI,
  output logic             SO,
  output logic             SO_VALID,
  output logic             SO_LAST
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt_q;
  logic             cnt_zero;
  logic             cnt_dec;
  logic             load_acc;

  // Remaining-bit counter: reads WIDTH-1 on the first bit, 0 on the last.
  m_bit_counter #(
    .CW (CW)
  ) u_bit_counter (
    .clk        (CLK),
    .clr        (CLR),
    .load       (load_acc),
    .dec        (cnt_dec),
    .load_value (CW'(WIDTH - 1)),
    .count      (cnt_q),
    .zero       (cnt_zero)
  );

  // Ready in IDLE or on the last bit, so a new word can follow with no gap.
  assign LOAD_READY = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && cnt_zero);
  assign load_acc   = LOAD_VALID && LOAD_READY;
  assign SO_LAST    = (state_q == ST_SHIFT) && cnt_zero;
  assign SO_VALID   = (state_q == ST_SHIFT);

  // Output bit sits at the sending end; zeros fill from the other end, so the
  // register is all-zero whenever the FSM is back in IDLE.
  assign SO           = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_q[WIDTH-1:1]};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_dec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_acc) begin
          state_d = ST_SHIFT;
          sreg_d  = PI;
        end
      end
      ST_SHIFT: begin
        sreg_d = sreg_shifted;
        if (load_acc) begin
          sreg_d = PI;
        end else if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and shift register.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

endmodule
